// File: rtl/synth_channel_env.sv
// synth_channel_env: phase-accumulator synth voice with ADSR envelope.
// Optional SYNTH_PWM_EN adds a duty_i port for pulse-width square waves.
module synth_channel_env #(
   parameter int PHASE_W = 24,
   parameter int INC_W   = 16,
   parameter int OUT_W   = 11,
   parameter int ENV_W   = 8
) (
   input  logic               clk_i,
   input  logic               rst_ni,
   input  logic               sample_tick_i,
   input  logic               ena_i,
   input  logic               gate_i,
   input  logic [INC_W-1:0]   freq_inc_i,
   input  logic [1:0]         waveform_i,
   input  logic [ENV_W-1:0]   attack_i,
   input  logic [ENV_W-1:0]   decay_i,
   input  logic [ENV_W-1:0]   sustain_i,
   input  logic [ENV_W-1:0]   release_i,
`ifdef SYNTH_PWM_EN
   input  logic [7:0]         duty_i,
`endif
   output logic [OUT_W-1:0]   out_o,
   output logic [2:0]         env_state_o,
   output logic               active_o,
   output logic               wrap_o
);

   localparam logic [2:0] S_IDLE    = 3'd0;
   localparam logic [2:0] S_ATTACK  = 3'd1;
   localparam logic [2:0] S_DECAY   = 3'd2;
   localparam logic [2:0] S_SUSTAIN = 3'd3;
   localparam logic [2:0] S_RELEASE = 3'd4;

   localparam logic [OUT_W-1:0] WMAX = {OUT_W{1'b1}};
   localparam logic [ENV_W-1:0] LMAX = {ENV_W{1'b1}};
   localparam logic [22:0]      TAPS = 23'h420000;

   logic [PHASE_W-1:0] phase_q, phase_d;
   logic [ENV_W-1:0]   level_q, level_d;
   logic [2:0]         state_q, state_d;
   logic [OUT_W-1:0]   out_q, out_d;
   logic               wrap_q, wrap_d;
   logic [22:0]        lfsr_q, lfsr_d;

   logic               step;
   logic [PHASE_W:0]   phase_sum;
   logic [OUT_W-1:0]   t;
   logic [OUT_W-1:0]   tri_v;
   logic [OUT_W-1:0]   sq_v;
   logic [OUT_W-1:0]   wave;
   logic [22:0]        lfsr_nxt;
   logic [ENV_W:0]     att_sum;
   logic [ENV_W:0]     dec_dif;
   logic [ENV_W:0]     rel_dif;
   logic [OUT_W+ENV_W-1:0] prod;

   assign step      = sample_tick_i & ena_i;
   assign phase_sum = {1'b0, phase_q}
                    + {{(PHASE_W+1-INC_W){1'b0}}, freq_inc_i};
   assign t         = phase_q[PHASE_W-1 -: OUT_W];
   assign tri_v     = {t[OUT_W-2:0], 1'b0};
   assign lfsr_nxt  = {1'b0, lfsr_q[22:1]}
                    ^ (lfsr_q[0] ? TAPS : 23'h0);

`ifdef SYNTH_PWM_EN
   assign sq_v = (phase_q[PHASE_W-1 -: 8] < duty_i) ? WMAX : '0;
`else
   assign sq_v = phase_q[PHASE_W-1] ? '0 : WMAX;
`endif

   // Waveform select from the current phase and noise register
   always_comb begin
      wave = '0;
      unique case (waveform_i)
         2'b00: wave = sq_v;
         2'b01: wave = phase_q[PHASE_W-1] ? ~tri_v : tri_v;
         2'b10: wave = t;
         2'b11: wave = lfsr_q[22 -: OUT_W];
         default: wave = '0;
      endcase
   end

   // Phase advance, wrap detect and noise stepping on each sample tick
   always_comb begin
      phase_d = phase_q;
      wrap_d  = 1'b0;
      lfsr_d  = lfsr_q;
      if (!ena_i) begin
         phase_d = '0;
      end else if (sample_tick_i) begin
         phase_d = phase_sum[PHASE_W-1:0];
         wrap_d  = phase_sum[PHASE_W];
         if (phase_sum[PHASE_W]) lfsr_d = lfsr_nxt;
      end
   end

   assign att_sum = {1'b0, level_q} + {1'b0, attack_i};
   assign dec_dif = {1'b0, level_q} - {1'b0, decay_i};
   assign rel_dif = {1'b0, level_q} - {1'b0, release_i};

   // ADSR next state; rate maths is one bit wider to catch over/underflow
   always_comb begin
      state_d = state_q;
      level_d = level_q;
      if (!ena_i) begin
         state_d = S_IDLE;
         level_d = '0;
      end else if (step) begin
         unique case (state_q)
            S_IDLE: begin
               if (gate_i) state_d = S_ATTACK;
            end
            S_ATTACK: begin
               if (!gate_i) begin
                  state_d = S_RELEASE;
               end else if (attack_i == '0 || att_sum >= {1'b0, LMAX}) begin
                  level_d = LMAX;
                  state_d = S_DECAY;
               end else begin
                  level_d = att_sum[ENV_W-1:0];
               end
            end
            S_DECAY: begin
               if (!gate_i) begin
                  state_d = S_RELEASE;
               end else if (sustain_i >= level_q || decay_i == '0
                            || dec_dif[ENV_W]
                            || dec_dif[ENV_W-1:0] <= sustain_i) begin
                  level_d = sustain_i;
                  state_d = S_SUSTAIN;
               end else begin
                  level_d = dec_dif[ENV_W-1:0];
               end
            end
            S_SUSTAIN: begin
               if (!gate_i) state_d = S_RELEASE;
               else         level_d = sustain_i;
            end
            S_RELEASE: begin
               if (gate_i) begin
                  state_d = S_ATTACK;
               end else if (release_i == '0 || rel_dif[ENV_W]
                            || rel_dif[ENV_W-1:0] == '0) begin
                  level_d = '0;
                  state_d = S_IDLE;
               end else begin
                  level_d = rel_dif[ENV_W-1:0];
               end
            end
            default: begin
               state_d = S_IDLE;
               level_d = '0;
            end
         endcase
      end
   end

   assign prod  = {{ENV_W{1'b0}}, wave} * {{OUT_W{1'b0}}, level_q};
   assign out_d = ena_i ? prod[OUT_W+ENV_W-1:ENV_W] : '0;

   // Oscillator state registers
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         phase_q <= '0;
         wrap_q  <= 1'b0;
         lfsr_q  <= '1;
      end else begin
         phase_q <= phase_d;
         wrap_q  <= wrap_d;
         lfsr_q  <= lfsr_d;
      end
   end

   // Envelope state and level registers
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= S_IDLE;
         level_q <= '0;
      end else begin
         state_q <= state_d;
         level_q <= level_d;
      end
   end

   // Registered enveloped output sample
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) out_q <= '0;
      else         out_q <= out_d;
   end

   assign out_o       = out_q;
   assign env_state_o = state_q;
   assign active_o    = (state_q != S_IDLE);
   assign wrap_o      = wrap_q;

endmodule

// File: tb/tb_synth_channel_env.sv
// tb_synth_channel_env: directed bench for synth_channel_env.
// Covers reset, saw pitch, ADSR, retrigger, noise LFSR and enable.
module tb_synth_channel_env;

   logic        clk;
   logic        rst_n;
   logic        tick;
   logic        ena;
   logic        gate;
   logic [15:0] finc;
   logic [1:0]  wf;
   logic [7:0]  att, dec, sus, rel;
`ifdef SYNTH_PWM_EN
   logic [7:0]  duty;
`endif
   logic [10:0] out;
   logic [2:0]  st;
   logic        act;
   logic        wrp;

   int n_chk  = 0;
   int n_pass = 0;

   logic [22:0] lfsr_m;

   synth_channel_env dut (
      .clk_i         (clk),
      .rst_ni        (rst_n),
      .sample_tick_i (tick),
      .ena_i         (ena),
      .gate_i        (gate),
      .freq_inc_i    (finc),
      .waveform_i    (wf),
      .attack_i      (att),
      .decay_i       (dec),
      .sustain_i     (sus),
      .release_i     (rel),
`ifdef SYNTH_PWM_EN
      .duty_i        (duty),
`endif
      .out_o         (out),
      .env_state_o   (st),
      .active_o      (act),
      .wrap_o        (wrp)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input int got, input int exp);
      n_chk++;
      if (got == exp) n_pass++;
      else $display("FAIL %s got %0d exp %0d", tag, got, exp);
   endtask

   function automatic int sq_out(input int l);
      return (2047 * l) >> 8;
   endfunction

   function automatic logic [22:0] lfsr_step(input logic [22:0] v);
      logic [22:0] r;
      r = v >> 1;
      if (v[0]) r = r ^ 23'h420000;
      return r;
   endfunction

   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0;
      ena   = 1'b0;
      tick  = 1'b0;
      gate  = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   // one sample tick, then one idle clk so out reflects the new level
   task automatic env_tick();
      tick = 1'b1;
      @(negedge clk);
      tick = 1'b0;
      @(negedge clk);
   endtask

   task automatic env_chk(input string tag, input int l, input int s);
      chk({tag, "_out"}, out, sq_out(l));
      chk({tag, "_st"}, st, s);
   endtask

   task automatic wait_wrap(output int n);
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!wrp && n < 1000);
      chk("wrap_seen", wrp, 1);
   endtask

   initial begin
      int n;
      int l;
      int mx;
      int w1, w2, nw;
      rst_n = 1'b0;
      tick  = 1'b0;
      ena   = 1'b0;
      gate  = 1'b0;
      finc  = '0;
      wf    = 2'b00;
      att   = '0;
      dec   = '0;
      sus   = '0;
      rel   = '0;
`ifdef SYNTH_PWM_EN
      duty  = 8'd128;
`endif
      #12;
      chk("rst_out", out, 0);
      chk("rst_st", st, 0);
      chk("rst_act", act, 0);
      chk("rst_wrap", wrp, 0);

      // reset mid-note at level 200
      do_reset();
      ena = 1'b1; gate = 1'b1; att = 8'd200; sus = 8'd128;
      env_tick();
      env_tick();
      env_chk("pre_rst", 200, 1);
      #2 rst_n = 1'b0;
      #1;
      chk("arst_out", out, 0);
      chk("arst_st", st, 0);
      chk("arst_act", act, 0);
      chk("arst_wrap", wrp, 0);
      @(negedge clk);
      rst_n = 1'b1;

      // saw pitch
      do_reset();
      wf = 2'b10; att = 8'd0; dec = 8'd0; sus = 8'd255;
      finc = 16'h8000; gate = 1'b1; ena = 1'b1; tick = 1'b1;
      mx = 0; w1 = 0; w2 = 0; nw = 0;
      for (int c = 1; c <= 1100; c++) begin
         @(negedge clk);
         if (out > mx) mx = out;
         if (wrp) begin
            nw++;
            if (nw == 1) w1 = c;
            if (nw == 2) w2 = c;
         end
         if (c == 100) chk("saw_100", out, 394);
         if (c == 512) chk("saw_peak_c", out, 2036);
         if (c == 513) chk("saw_zero", out, 0);
      end
      chk("saw_w1", w1, 512);
      chk("saw_w2", w2, 1024);
      chk("saw_nw", nw, 2);
      chk("saw_max", mx, 2036);

      // envelope
      do_reset();
      wf = 2'b00; finc = 16'h0; ena = 1'b1; gate = 1'b1;
      att = 8'd16; dec = 8'd8; sus = 8'd128; rel = 8'd4;
      env_tick();
      env_chk("idle2att", 0, 1);
      chk("att_act", act, 1);
      for (int k = 1; k <= 16; k++) begin
         env_tick();
         env_chk("att", (k < 16) ? 16 * k : 255, (k < 16) ? 1 : 2);
      end
      for (int k = 1; k <= 16; k++) begin
         env_tick();
         env_chk("dec", (k < 16) ? 255 - 8 * k : 128, (k < 16) ? 2 : 3);
      end
      env_tick();
      env_chk("sus", 128, 3);
      gate = 1'b0;
      env_tick();
      env_chk("rel0", 128, 4);
      for (int k = 1; k <= 32; k++) begin
         env_tick();
         env_chk("rel", 128 - 4 * k, (k < 32) ? 4 : 0);
         chk("rel_act", act, (k < 32) ? 1 : 0);
      end

      // retrigger from release at level 60
      gate = 1'b1;
      env_tick();
      repeat (16) env_tick();
      repeat (16) env_tick();
      env_chk("n2_sus", 128, 3);
      gate = 1'b0;
      env_tick();
      repeat (17) env_tick();
      env_chk("n2_rel", 60, 4);
      gate = 1'b1;
      env_tick();
      env_chk("retrig", 60, 1);
      env_tick();
      env_chk("retrig_up", 76, 1);

      // enable drop mid-attack
      ena = 1'b0;
      @(negedge clk);
      chk("ena0_out", out, 0);
      chk("ena0_st", st, 0);
      chk("ena0_act", act, 0);
      ena = 1'b1;
      env_tick();
      env_chk("ena1_att", 0, 1);
      env_tick();
      env_chk("ena1_lvl", 16, 1);

      // noise
      do_reset();
      wf = 2'b11; finc = 16'hFFFF; att = 8'd0; dec = 8'd0;
      sus = 8'd255; gate = 1'b1; ena = 1'b1; tick = 1'b1;
      lfsr_m = '1;
      for (int w = 0; w < 80; w++) begin
         wait_wrap(n);
         if (w == 0 || w == 21) chk("nz_period", n, 257);
         lfsr_m = lfsr_step(lfsr_m);
         @(negedge clk);
         l = int'(lfsr_m[22:12]);
         chk("nz_out", out, (l * 255) >> 8);
         if (w == 20) begin
            ena = 1'b0;
            @(negedge clk);
            chk("nz_ena0_out", out, 0);
            chk("nz_ena0_st", st, 0);
            chk("nz_ena0_wrap", wrp, 0);
            ena = 1'b1;
         end
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
